// File: rtl/wfr_axi_readback.sv
// wfr_axi_readback: AXI4 read master that fetches a recorded waveform from DRAM
// and streams it to a downstream consumer with valid/ready flow control.
// A request is split into bursts of at most MAX_BURST_LEN beats. No burst
// crosses a 4 KiB page, and only one burst is in flight at a time.
module wfr_axi_readback #(
    parameter int AXI_ADDR_WIDTH = 35,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int MAX_BURST_LEN  = 16,
    parameter int COUNT_WIDTH    = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    // request / status
    input  logic                      start,
    input  logic [AXI_ADDR_WIDTH-1:0] startAddress,
    input  logic [COUNT_WIDTH-1:0]    beatCount,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    // AXI read address channel
    output logic [AXI_ADDR_WIDTH-1:0] axi_ARADDR,
    output logic [7:0]                axi_ARLEN,
    output logic                      axi_ARVALID,
    input  logic                      axi_ARREADY,
    // AXI read data channel
    input  logic [AXI_DATA_WIDTH-1:0] axi_RDATA,
    input  logic [1:0]                axi_RRESP,
    input  logic                      axi_RLAST,
    input  logic                      axi_RVALID,
    output logic                      axi_RREADY,
    // output stream
    output logic [AXI_DATA_WIDTH-1:0] outData,
    output logic                      outValid,
    input  logic                      outReady
);

    // Bytes per beat and the number of address bits below one beat.
    localparam int BPB   = AXI_DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BPB);
    // Width for burst-length arithmetic: wide enough for the beat counter and
    // for the 4096-byte page distance.
    localparam int LW    = (COUNT_WIDTH > 13) ? COUNT_WIDTH : 13;

    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~AXI_ADDR_WIDTH'(BPB - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(BPB);
    localparam logic [1:0]                RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_e;

    state_e                      state_q,      state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q,       addr_d;
    logic [COUNT_WIDTH-1:0]      remaining_q,  remaining_d;
    logic [8:0]                  beats_left_q, beats_left_d;
    logic                        busy_q,       busy_d;
    logic                        done_q,       done_d;
    logic                        error_q,      error_d;
    logic [AXI_ADDR_WIDTH-1:0]   araddr_q,     araddr_d;
    logic [7:0]                  arlen_q,      arlen_d;
    logic                        arvalid_q,    arvalid_d;
    logic [AXI_DATA_WIDTH-1:0]   out_data_q,   out_data_d;
    logic                        out_valid_q,  out_valid_d;

    logic [LW-1:0]               page_beats;
    logic [LW-1:0]               len_w;
    logic                        rready;
    logic                        r_hs;
    logic                        last_beat;

    // Length of the next burst: the smallest of the burst cap, the beats still
    // owed, and the beats left before the next 4 KiB page boundary.
    always_comb begin
        page_beats = LW'((13'd4096 - {1'b0, addr_q[11:0]}) >> OFF_W);
        len_w      = LW'(MAX_BURST_LEN);
        if (LW'(remaining_q) < len_w) begin
            len_w = LW'(remaining_q);
        end
        if (page_beats < len_w) begin
            len_w = page_beats;
        end
    end

    // R channel is accepted only in DATA, and only if the output register is
    // free or is draining in this same cycle. This keeps every beat.
    assign rready    = (state_q == S_DATA) && (!out_valid_q || outReady);
    assign r_hs      = axi_RVALID && rready;
    assign last_beat = (beats_left_q == 9'd1);

    // Next-state and next-output computation for the read sequencer and the
    // output register.
    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through this block infers a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        beats_left_d = beats_left_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arvalid_d    = arvalid_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = startAddress & ADDR_MASK;
                    remaining_d = beatCount;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = (beatCount == '0) ? S_DONE : S_ADDR;
                end
            end

            S_ADDR: begin
                if (!arvalid_q) begin
                    // Address and length are captured once and then held
                    // until the interconnect accepts them.
                    araddr_d  = addr_q;
                    arlen_d   = 8'(len_w - LW'(1));
                    arvalid_d = 1'b1;
                end else if (axi_ARREADY) begin
                    arvalid_d    = 1'b0;
                    beats_left_d = {1'b0, arlen_q} + 9'd1;
                    state_d      = S_DATA;
                end
            end

            S_DATA: begin
                if (r_hs) begin
                    beats_left_d = beats_left_q - 9'd1;
                    remaining_d  = remaining_q - COUNT_WIDTH'(1);
                    addr_d       = addr_q + ADDR_STEP;
                    // A bad response or a misplaced RLAST is recorded, but
                    // the beat is still delivered.
                    if (axi_RRESP != RESP_OKAY) begin
                        error_d = 1'b1;
                    end
                    if (axi_RLAST != last_beat) begin
                        error_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = (remaining_q != COUNT_WIDTH'(1)) ? S_ADDR : S_DONE;
                    end
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The output register is independent of the sequencer state. The
        // final beat may still be draining after the request has finished.
        if (r_hs) begin
            out_data_d  = axi_RDATA;
            out_valid_d = 1'b1;
        end else if (out_valid_q && outReady) begin
            out_valid_d = 1'b0;
        end
    end

    // State and registered outputs. Reset abandons any burst in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            beats_left_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the pre-edge values of the others.
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            beats_left_q <= beats_left_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arvalid_q    <= arvalid_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign axi_ARADDR  = araddr_q;
    assign axi_ARLEN   = arlen_q;
    assign axi_ARVALID = arvalid_q;
    assign axi_RREADY  = rready;
    assign outData     = out_data_q;
    assign outValid    = out_valid_q;

endmodule

// File: tb/tb_wfr_axi_readback.sv
// Directed testbench for wfr_axi_readback. A small AXI read slave answers
// every accepted AR with beats whose data encodes the beat address. The
// consumer side records every delivered beat. The main sequence compares the
// recorded AR and beat logs with hand-computed expectations.
module tb_wfr_axi_readback;

    localparam int AW = 35;
    localparam int DW = 128;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] startAddress;
    logic [CW-1:0] beatCount;
    logic          busy, done, error;
    logic [AW-1:0] axi_ARADDR;
    logic [7:0]    axi_ARLEN;
    logic          axi_ARVALID, axi_ARREADY;
    logic [DW-1:0] axi_RDATA;
    logic [1:0]    axi_RRESP;
    logic          axi_RLAST, axi_RVALID, axi_RREADY;
    logic [DW-1:0] outData;
    logic          outValid, outReady;

    wfr_axi_readback #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .MAX_BURST_LEN (16),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .startAddress(startAddress),
        .beatCount   (beatCount),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .axi_ARADDR  (axi_ARADDR),
        .axi_ARLEN   (axi_ARLEN),
        .axi_ARVALID (axi_ARVALID),
        .axi_ARREADY (axi_ARREADY),
        .axi_RDATA   (axi_RDATA),
        .axi_RRESP   (axi_RRESP),
        .axi_RLAST   (axi_RLAST),
        .axi_RVALID  (axi_RVALID),
        .axi_RREADY  (axi_RREADY),
        .outData     (outData),
        .outValid    (outValid),
        .outReady    (outReady)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // slave / consumer state shared with the directed sequence
    bit            rnd_mode    = 1'b0;
    int            err_beat    = -1;
    int            s_beats     = 0;
    int            s_idx       = 0;
    logic [AW-1:0] s_addr      = '0;
    bit            r_taken     = 1'b0;
    bit            err_pend    = 1'b0;
    logic          err_at_beat;
    logic          err_after_beat;
    int            done_cnt    = 0;
    int            rready_viol = 0;
    logic [DW-1:0] out_q[$];
    logic [AW-1:0] ar_addr_q[$];
    logic [7:0]    ar_len_q[$];

    function automatic logic [DW-1:0] beat_data(logic [AW-1:0] a);
        logic [31:0] w;
        w = a[31:0];
        return {w ^ 32'hDA7A_0000, w, ~w, w + 32'h1234_5678};
    endfunction

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AXI slave and output consumer. Inputs are driven on the falling edge.
    // 1 time unit later the handshakes due at the next rising edge are logged.
    initial begin
        axi_ARREADY = 1'b0;
        axi_RVALID  = 1'b0;
        axi_RDATA   = '0;
        axi_RRESP   = 2'b00;
        axi_RLAST   = 1'b0;
        outReady    = 1'b0;
        forever begin
            @(negedge clk);
            if (r_taken) begin
                axi_RVALID = 1'b0;
                r_taken    = 1'b0;
            end
            axi_ARREADY = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            outReady    = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (!axi_RVALID && s_beats != 0 && (!rnd_mode || $urandom_range(0, 2) != 0)) begin
                axi_RVALID = 1'b1;
                axi_RDATA  = beat_data(s_addr);
                axi_RLAST  = (s_beats == 1);
                axi_RRESP  = (s_idx == err_beat) ? 2'b10 : 2'b00;
            end
            #1;
            if (reset) begin
                s_beats    = 0;
                axi_RVALID = 1'b0;
                r_taken    = 1'b0;
                err_pend   = 1'b0;
            end else begin
                if (err_pend) begin
                    err_after_beat = error;
                    err_pend       = 1'b0;
                end
                if (axi_ARVALID && axi_ARREADY) begin
                    ar_addr_q.push_back(axi_ARADDR);
                    ar_len_q.push_back(axi_ARLEN);
                    s_addr  = axi_ARADDR;
                    s_beats = int'(axi_ARLEN) + 1;
                end
                if (axi_RVALID && axi_RREADY) begin
                    if (s_idx == err_beat) begin
                        err_at_beat = error;
                        err_pend    = 1'b1;
                    end
                    s_addr  = s_addr + AW'(16);
                    s_beats = s_beats - 1;
                    s_idx   = s_idx + 1;
                    r_taken = 1'b1;
                end
                if (axi_RREADY && outValid && !outReady) rready_viol++;
                if (outValid && outReady) out_q.push_back(outData);
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        out_q.delete();
        ar_addr_q.delete();
        ar_len_q.delete();
        s_idx    = 0;
        done_cnt = 0;
    endtask

    task automatic do_start(logic [AW-1:0] a, logic [CW-1:0] n);
        @(negedge clk);
        startAddress = a;
        beatCount    = n;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic wait_finish(string tag, int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done seen"}, DW'(done_cnt != 0), DW'(1));
        n = 0;
        while (outValid && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({tag, " drained"}, DW'(outValid), DW'(0));
    endtask

    task automatic check_beats(string tag, logic [AW-1:0] base, int n);
        chk({tag, " beat total"}, DW'(out_q.size()), DW'(n));
        for (int k = 0; k < n && k < out_q.size(); k++) begin
            chk($sformatf("%s beat %0d", tag, k), out_q[k], beat_data(base + AW'(16 * k)));
        end
    endtask

    task automatic check_ar(string tag, int idx, logic [AW-1:0] a, logic [7:0] l);
        if (idx < ar_addr_q.size()) begin
            chk($sformatf("%s ar%0d addr", tag, idx), DW'(ar_addr_q[idx]), DW'(a));
            chk($sformatf("%s ar%0d len", tag, idx), DW'(ar_len_q[idx]), DW'(l));
        end else begin
            chk($sformatf("%s ar%0d present", tag, idx), DW'(ar_addr_q.size()), DW'(idx + 1));
        end
    endtask

    task automatic check_idle_outputs(string tag);
        chk({tag, " busy"}, DW'(busy), DW'(0));
        chk({tag, " done"}, DW'(done), DW'(0));
        chk({tag, " error"}, DW'(error), DW'(0));
        chk({tag, " arvalid"}, DW'(axi_ARVALID), DW'(0));
        chk({tag, " rready"}, DW'(axi_RREADY), DW'(0));
        chk({tag, " outvalid"}, DW'(outValid), DW'(0));
        chk({tag, " araddr"}, DW'(axi_ARADDR), DW'(0));
        chk({tag, " arlen"}, DW'(axi_ARLEN), DW'(0));
        chk({tag, " outdata"}, outData, DW'(0));
    endtask

    initial begin
        int n;
        reset        = 1'b1;
        start        = 1'b0;
        startAddress = '0;
        beatCount    = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: 40 beats from 0x10000, everything always ready
        clear_log();
        do_start(AW'('h10000), CW'(40));
        chk("t1 busy after start", DW'(busy), DW'(1));
        chk("t1 arvalid 1 cycle after start", DW'(axi_ARVALID), DW'(0));
        @(negedge clk);
        chk("t1 arvalid 2 cycles after start", DW'(axi_ARVALID), DW'(1));
        chk("t1 first araddr", DW'(axi_ARADDR), DW'('h10000));
        chk("t1 first arlen", DW'(axi_ARLEN), DW'(15));
        wait_finish("t1", 500);
        chk("t1 ar total", DW'(ar_addr_q.size()), DW'(3));
        check_ar("t1", 0, AW'('h10000), 8'd15);
        check_ar("t1", 1, AW'('h10100), 8'd15);
        check_ar("t1", 2, AW'('h10200), 8'd7);
        check_beats("t1", AW'('h10000), 40);
        chk("t1 done pulses", DW'(done_cnt), DW'(1));
        chk("t1 busy at end", DW'(busy), DW'(0));
        chk("t1 error at end", DW'(error), DW'(0));

        // 2: 10 beats starting 64 bytes below a 4 KiB boundary
        clear_log();
        do_start(AW'('h10FC0), CW'(10));
        wait_finish("t2", 500);
        chk("t2 ar total", DW'(ar_addr_q.size()), DW'(2));
        check_ar("t2", 0, AW'('h10FC0), 8'd3);
        check_ar("t2", 1, AW'('h11000), 8'd5);
        check_beats("t2", AW'('h10FC0), 10);

        // 3: repeat of test 1 with random consumer stalls and R gaps
        clear_log();
        rready_viol = 0;
        rnd_mode    = 1'b1;
        do_start(AW'('h10000), CW'(40));
        wait_finish("t3", 3000);
        rnd_mode = 1'b0;
        chk("t3 ar total", DW'(ar_addr_q.size()), DW'(3));
        check_ar("t3", 0, AW'('h10000), 8'd15);
        check_ar("t3", 1, AW'('h10100), 8'd15);
        check_ar("t3", 2, AW'('h10200), 8'd7);
        check_beats("t3", AW'('h10000), 40);
        chk("t3 rready while output stalled", DW'(rready_viol), DW'(0));
        chk("t3 done pulses", DW'(done_cnt), DW'(1));

        // 4: SLVERR on beat 5
        clear_log();
        err_beat       = 4;
        err_at_beat    = 1'bx;
        err_after_beat = 1'bx;
        do_start(AW'('h10000), CW'(40));
        chk("t4 error after start", DW'(error), DW'(0));
        wait_finish("t4", 500);
        err_beat = -1;
        chk("t4 error during beat 5", DW'(err_at_beat), DW'(0));
        chk("t4 error after beat 5", DW'(err_after_beat), DW'(1));
        chk("t4 error sticky", DW'(error), DW'(1));
        check_beats("t4", AW'('h10000), 40);
        chk("t4 done pulses", DW'(done_cnt), DW'(1));
        clear_log();
        do_start(AW'('h10000), CW'(4));
        chk("t4 error cleared by start", DW'(error), DW'(0));
        wait_finish("t4b", 200);
        check_beats("t4b", AW'('h10000), 4);

        // 5a: zero-length request
        clear_log();
        do_start(AW'('h40000), CW'(0));
        chk("t5 busy after start", DW'(busy), DW'(1));
        chk("t5 done 1 cycle after start", DW'(done), DW'(0));
        @(negedge clk);
        chk("t5 done 2 cycles after start", DW'(done), DW'(1));
        chk("t5 busy with done", DW'(busy), DW'(0));
        @(negedge clk);
        chk("t5 done single cycle", DW'(done), DW'(0));
        repeat (3) @(negedge clk);
        chk("t5 no ar", DW'(ar_addr_q.size()), DW'(0));
        chk("t5 done pulses", DW'(done_cnt), DW'(1));

        // 5b: start while busy is ignored
        clear_log();
        do_start(AW'('h20000), CW'(8));
        repeat (3) @(negedge clk);
        do_start(AW'('h30000), CW'(5));
        wait_finish("t5b", 300);
        repeat (10) @(negedge clk);
        chk("t5b ar total", DW'(ar_addr_q.size()), DW'(1));
        check_ar("t5b", 0, AW'('h20000), 8'd7);
        check_beats("t5b", AW'('h20000), 8);
        chk("t5b done pulses", DW'(done_cnt), DW'(1));

        // 6: reset mid-burst, then a short request
        clear_log();
        do_start(AW'('h10000), CW'(40));
        n = 0;
        while (out_q.size() < 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t6 reached mid-burst", DW'(out_q.size() >= 10), DW'(1));
        reset = 1'b1;
        #1;
        check_idle_outputs("t6 async reset");
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        do_start(AW'('h10000), CW'(4));
        wait_finish("t6", 200);
        chk("t6 ar total", DW'(ar_addr_q.size()), DW'(1));
        check_ar("t6", 0, AW'('h10000), 8'd3);
        check_beats("t6", AW'('h10000), 4);
        chk("t6 done pulses", DW'(done_cnt), DW'(1));
        chk("t6 error", DW'(error), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
